// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte queue feeding a UART transmitter handshake.
// Define UART_TXQ_DROP_EN to make it never back-pressure: bytes pushed while full are dropped and counted.
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  SCLK,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  input  logic [WIDTH-1:0]      IN_DATA,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  output logic [WIDTH-1:0]      OUT_DATA,
  input  logic                  OUT_READY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef UART_TXQ_DROP_EN
  ,
  output logic [15:0]           DROP_COUNT
`endif
);
  localparam int AW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic push, pop;
  assign FULL      = count_q == AW'(DEPTH);
  assign EMPTY     = count_q == '0;
  assign COUNT     = count_q;
  assign OUT_VALID = ~EMPTY;
  assign OUT_DATA  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
`ifdef UART_TXQ_DROP_EN
  assign IN_READY = 1'b1;
`else
  assign IN_READY = ~FULL;
`endif
  // Push is gated on ~FULL in both builds so a drop mode push never overwrites the head.
  always_comb begin
    push     = IN_VALID & IN_READY & ~FULL & ~FLUSH;
    pop      = OUT_VALID & OUT_READY & ~FLUSH;
    wr_ptr_d = FLUSH ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = FLUSH ? '0 : rd_ptr_q + AW'(pop);
    count_d  = FLUSH ? '0 : count_q + AW'(push) - AW'(pop);
  end
  always_ff @(posedge SCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge SCLK) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= IN_DATA;
  end
`ifdef UART_TXQ_DROP_EN
  logic [15:0] drop_q, drop_d;
  always_comb drop_d = (IN_VALID & FULL & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  always_ff @(posedge SCLK or negedge RESET_N) begin
    if (!RESET_N) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign DROP_COUNT = drop_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
  logic SCLK = 0, RESET_N = 0, FLUSH = 0, IN_VALID = 0, OUT_READY = 0;
  logic [7:0] IN_DATA = '0;
  logic IN_READY, OUT_VALID, FULL, EMPTY;
  logic [7:0] OUT_DATA;
  logic [4:0] COUNT;
  int n_chk = 0, n_fail = 0, drops = 0, pushed = 0;
  logic [7:0] q[$];
`ifdef UART_TXQ_DROP_EN
  logic [15:0] DROP_COUNT;
  localparam bit DROP = 1;
`else
  localparam bit DROP = 0;
`endif

  uart_tx_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .SCLK(SCLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
`ifdef UART_TXQ_DROP_EN
    , .DROP_COUNT(DROP_COUNT)
`endif
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count"}, int'(COUNT), q.size());
    chk({tag, " empty"}, int'(EMPTY), int'(q.size() == 0));
    chk({tag, " full"}, int'(FULL), int'(q.size() == 16));
    chk({tag, " out_valid"}, int'(OUT_VALID), int'(q.size() != 0));
    chk({tag, " in_ready"}, int'(IN_READY), DROP ? 1 : int'(q.size() != 16));
    if (q.size() != 0) chk({tag, " out_data"}, int'(OUT_DATA), int'(q[0]));
`ifdef UART_TXQ_DROP_EN
    chk({tag, " drop_count"}, int'(DROP_COUNT), drops);
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the handshake rules, then check after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic r, input logic f);
    bit full;
    IN_VALID = v; IN_DATA = d; OUT_READY = r; FLUSH = f;
    full = q.size() == 16;
    @(posedge SCLK);
    #1;
    if (v && full && drops < 65535) drops += DROP;
    if (f) q.delete();
    else begin
      if (r && q.size() != 0) void'(q.pop_front());
      if (v && !full) begin q.push_back(d); pushed++; end
    end
    check_all(tag);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge SCLK); RESET_N = 1;
    @(posedge SCLK); #1;
    check_all("post_reset");
    step("single", 1, 8'hA5, 0, 0);
    step("single_pop", 0, 8'h00, 1, 0);
    chk("single_empty", int'(EMPTY), 1);
    for (int i = 0; i < 16; i++) step("fill", 1, 8'(i), 0, 0);
    chk("fill_full", int'(FULL), 1);
    step("fill_17th", 1, 8'hFF, 0, 0);
    step("full_push_pop", 1, 8'hEE, 1, 0);
    chk("full_push_pop_count", int'(COUNT), 15);
    while (q.size() != 0) step("drain", 0, 8'h00, 1, 0);
    step("empty_push_pop", 1, 8'h3C, 1, 0);
    chk("empty_push_pop_count", int'(COUNT), 1);
    step("drain1", 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step("wrap_pre", 1, 8'($urandom), 0, 0);
    pushed = 0;
    for (int i = 0; i < 400 && pushed < 40; i++) begin
      logic v, r;
      v = (q.size() < 4) || (q.size() < 5 && $urandom_range(1) == 1);
      r = q.size() > 3 && $urandom_range(1) == 1;
      step("wrap", v, 8'($urandom), r, 0);
    end
    chk("wrap_pushed", pushed, 40);
    while (q.size() < 7) step("flush_pre", 1, 8'($urandom), 0, 0);
    step("flush", 1, 8'h77, 1, 1);
    chk("flush_empty", int'(EMPTY), 1);
    for (int i = 0; i < 3; i++) step("refill", 1, 8'h50 + 8'(i), 0, 0);
    #2 RESET_N = 0;
    #1;
    q.delete(); drops = 0;
    chk("async_rst_valid", int'(OUT_VALID), 0);
    check_all("async_rst");
    #1 RESET_N = 1;
    for (int i = 0; i < 5; i++) step("hello", 1, 8'("HELLO" >> (8 * (4 - i))), 0, 0);
    for (int i = 0; i < 600; i++)
      step("random", $urandom_range(3) != 0, 8'($urandom), $urandom_range(2) == 0, $urandom_range(63) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
